adder_tree_sched: RTL and testbench

Sequencer for the matrix-vector datapath's shared multiply / adder-tree pipeline. It issues the six rows of a 6x6 matrix-vector product into the pipeline on consecutive cycles. It tracks each row through the fixed pipeline latency with a tag shift register and assembles the six 32-bit sums into a 192-bit result vector. The downstream FP pipeline has no backpressure (tready tied high), so this block never stalls issue and relies entirely on latency tracking.

---
 rtl/adder_tree_sched.sv | 155 +++++++++++++++
 tb/tb_adder_tree_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_tree_sched.sv
// Issue/drain sequencer for the shared multiply + 3-level adder-tree pipeline.
// Issues six matrix rows back to back and collects their sums through a latency-matched tag pipe.
module adder_tree_sched #(
    parameter int DELAY_MUL = 6,
    parameter int DELAY_ADD = 12
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         start,
    output logic         busy,
    output logic         done,
    output logic         issue,
    output logic [2:0]   row_sel,
    input  logic [31:0]  sum_in,
    output logic [191:0] y_out
);

    localparam int PIPE_LAT = DELAY_MUL + 3 * DELAY_ADD;
    localparam logic [2:0] LAST_ROW = 3'd5;
    localparam logic [2:0] NUM_ROWS = 3'd6;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         state_r;
    logic [2:0]     issue_cnt_r;
    logic [2:0]     cap_cnt_r;
    logic           busy_r;
    logic           done_r;
    logic           issue_r;
    logic [2:0]     row_sel_r;
    logic [191:0]   y_r;
    logic [3:0]     tag_r [PIPE_LAT];

    logic           tap_valid_s;
    logic [2:0]     tap_idx_s;
    logic [2:0]     cap_cnt_nxt_s;

    // Output tap of the tag pipe and the saturating capture count it implies.
    always_comb begin
        tap_valid_s   = tag_r[PIPE_LAT-1][3];
        tap_idx_s     = tag_r[PIPE_LAT-1][2:0];
        cap_cnt_nxt_s = cap_cnt_r;
        if (tap_valid_s && (cap_cnt_r != NUM_ROWS)) begin
            cap_cnt_nxt_s = cap_cnt_r + 3'd1;
        end else begin
            cap_cnt_nxt_s = cap_cnt_r;
        end
    end

    // Tag pipe: mirrors the datapath latency so each sum is matched to its row.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < PIPE_LAT; i++) begin
                tag_r[i] <= 4'd0;
            end
        end else begin
            tag_r[0] <= {issue_r, row_sel_r};
            for (int i = 1; i < PIPE_LAT; i++) begin
                tag_r[i] <= tag_r[i-1];
            end
        end
    end

    // Result capture: only tagged cycles write; sum_in is junk otherwise.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            y_r <= 192'd0;
        end else if (tap_valid_s) begin
            for (int r = 0; r < 6; r++) begin
                if (tap_idx_s == r[2:0]) begin
                    y_r[32*r +: 32] <= sum_in;
                end
            end
        end else begin
            y_r <= y_r;
        end
    end

    // Control FSM with registered status and issue outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r     <= ST_IDLE;
            issue_cnt_r <= 3'd0;
            cap_cnt_r   <= 3'd0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            issue_r     <= 1'b0;
            row_sel_r   <= 3'd0;
        end else begin
            cap_cnt_r <= cap_cnt_nxt_s;
            case (state_r)
                ST_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        state_r     <= ST_ISSUE;
                        issue_cnt_r <= 3'd0;
                        cap_cnt_r   <= 3'd0;
                        busy_r      <= 1'b1;
                        issue_r     <= 1'b1;
                        row_sel_r   <= 3'd0;
                    end else begin
                        busy_r    <= 1'b0;
                        issue_r   <= 1'b0;
                        row_sel_r <= 3'd0;
                    end
                end
                ST_ISSUE: begin
                    if (issue_cnt_r == LAST_ROW) begin
                        state_r   <= ST_DRAIN;
                        issue_r   <= 1'b0;
                        row_sel_r <= 3'd0;
                    end else begin
                        issue_cnt_r <= issue_cnt_r + 3'd1;
                        issue_r     <= 1'b1;
                        row_sel_r   <= issue_cnt_r + 3'd1;
                    end
                end
                ST_DRAIN: begin
                    // Decide on the next count so done lands the cycle after the last capture.
                    if (cap_cnt_nxt_s == NUM_ROWS) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_DRAIN;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r     <= ST_IDLE;
                    issue_cnt_r <= 3'd0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    issue_r     <= 1'b0;
                    row_sel_r   <= 3'd0;
                end
            endcase
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign issue   = issue_r;
    assign row_sel = row_sel_r;
    assign y_out   = y_r;

endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched: default instance (PIPE_LAT=42) and a short one (PIPE_LAT=7),
// each fed by a behavioural FP-pipeline model that returns tagged sums after the pipeline latency.
module tb_adder_tree_sched;

    logic         clk;
    logic         resetn;
    logic         start0, start1;
    logic         busy0, busy1, done0, done1, issue0, issue1;
    logic [2:0]   row_sel0, row_sel1;
    logic [31:0]  sum0, sum1;
    logic [191:0] y0, y1;

    int checks;
    int errors;
    int cyc;
    logic rand_mode;

    logic       s0_v [64];
    logic [2:0] s0_row [64];
    logic [7:0] s0_pass [64];
    logic       s1_v [64];
    logic [2:0] s1_row [64];
    logic [7:0] s1_pass [64];
    int pass_cnt0, pass_cnt1;
    logic [7:0] cur_pass0, cur_pass1;

    adder_tree_sched dut0 (
        .clk(clk), .resetn(resetn), .start(start0), .busy(busy0), .done(done0),
        .issue(issue0), .row_sel(row_sel0), .sum_in(sum0), .y_out(y0)
    );

    adder_tree_sched #(.DELAY_MUL(1), .DELAY_ADD(2)) dut1 (
        .clk(clk), .resetn(resetn), .start(start1), .busy(busy1), .done(done1),
        .issue(issue1), .row_sel(row_sel1), .sum_in(sum1), .y_out(y1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] model_sum(input logic [7:0] p, input logic [2:0] r);
        return 32'h4000_0000 | ({24'd0, p} << 8) | {29'd0, r};
    endfunction

    function automatic logic [191:0] build_y(input int p);
        logic [191:0] v;
        for (int r = 0; r < 6; r++) begin
            v[32*r +: 32] = model_sum(p[7:0], r[2:0]);
        end
        return v;
    endfunction

    // FP pipeline model: drives this cycle's sum, then records any operand issue for later return.
    always @(negedge clk) begin
        int idx;
        idx = cyc % 64;
        if (s0_v[idx]) begin
            sum0 = model_sum(s0_pass[idx], s0_row[idx]);
            s0_v[idx] = 1'b0;
        end else begin
            sum0 = rand_mode ? 32'($urandom) : 32'hDEAD_BEEF;
        end
        if (s1_v[idx]) begin
            sum1 = model_sum(s1_pass[idx], s1_row[idx]);
            s1_v[idx] = 1'b0;
        end else begin
            sum1 = rand_mode ? 32'($urandom) : 32'hDEAD_BEEF;
        end
        if (issue0 === 1'b1) begin
            if (row_sel0 == 3'd0) begin
                cur_pass0 = pass_cnt0[7:0];
                pass_cnt0++;
            end
            s0_v[(cyc + 42) % 64]    = 1'b1;
            s0_row[(cyc + 42) % 64]  = row_sel0;
            s0_pass[(cyc + 42) % 64] = cur_pass0;
        end
        if (issue1 === 1'b1) begin
            if (row_sel1 == 3'd0) begin
                cur_pass1 = pass_cnt1[7:0];
                pass_cnt1++;
            end
            s1_v[(cyc + 7) % 64]    = 1'b1;
            s1_row[(cyc + 7) % 64]  = row_sel1;
            s1_pass[(cyc + 7) % 64] = cur_pass1;
        end
    end

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy0, done0, issue0, row_sel0} !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctrl0 got %b required 000000", {busy0, done0, issue0, row_sel0});
        end
        checks++;
        if (y0 !== 192'd0) begin
            errors++;
            $display("FAIL reset_y0 got %h required 0", y0);
        end
        checks++;
        if ({busy1, done1, issue1, row_sel1} !== 6'd0) begin
            errors++;
            $display("FAIL reset_ctrl1 got %b required 000000", {busy1, done1, issue1, row_sel1});
        end
        checks++;
        if (y1 !== 192'd0) begin
            errors++;
            $display("FAIL reset_y1 got %h required 0", y1);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        logic [2:0] exp_row;
        start0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 56; k++) begin
            start0  = 1'b0;
            exp_row = (k <= 5) ? k[2:0] : 3'd0;
            checks++;
            if (issue0 !== (k <= 5)) begin
                errors++;
                $display("FAIL single_issue cycle %0d got %b required %b", k, issue0, (k <= 5));
            end
            checks++;
            if (row_sel0 !== exp_row) begin
                errors++;
                $display("FAIL single_row_sel cycle %0d got %0d required %0d", k, row_sel0, exp_row);
            end
            checks++;
            if (busy0 !== (k <= 47)) begin
                errors++;
                $display("FAIL single_busy cycle %0d got %b required %b", k, busy0, (k <= 47));
            end
            checks++;
            if (done0 !== (k == 48)) begin
                errors++;
                $display("FAIL single_done cycle %0d got %b required %b", k, done0, (k == 48));
            end
            if (k == 48) begin
                checks++;
                if (y0 !== build_y(0)) begin
                    errors++;
                    $display("FAIL single_y got %h required %h", y0, build_y(0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_start_busy;
        int n_issue;
        int n_done;
        n_issue = 0;
        n_done  = 0;
        start0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 61; k++) begin
            if (issue0 === 1'b1) n_issue++;
            if (done0 === 1'b1) n_done++;
            if (k == 55) begin
                checks++;
                if (y0 !== build_y(1)) begin
                    errors++;
                    $display("FAIL busy_start_y got %h required %h", y0, build_y(1));
                end
            end
            start0 = (k == 3) || (k == 20) || (k == 48);
            @(negedge clk);
        end
        start0 = 1'b0;
        checks++;
        if (n_issue != 6) begin
            errors++;
            $display("FAIL busy_start_issues got %0d required 6", n_issue);
        end
        checks++;
        if (n_done != 1) begin
            errors++;
            $display("FAIL busy_start_dones got %0d required 1", n_done);
        end
    endtask

    task automatic test_reset_mid;
        start0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 61; k++) begin
            start0 = 1'b0;
            if (k < 20) begin
                checks++;
                if (busy0 !== 1'b1) begin
                    errors++;
                    $display("FAIL midrst_busy_pre cycle %0d got %b required 1", k, busy0);
                end
            end
            if (k >= 21) begin
                checks++;
                if (y0 !== 192'd0) begin
                    errors++;
                    $display("FAIL midrst_y cycle %0d got %h required 0", k, y0);
                end
                checks++;
                if ({busy0, done0, issue0} !== 3'b000) begin
                    errors++;
                    $display("FAIL midrst_ctrl cycle %0d got %b required 000", k, {busy0, done0, issue0});
                end
            end
            resetn = (k == 20) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        resetn = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 56; k++) begin
            start0 = 1'b0;
            checks++;
            if (done0 !== (k == 48)) begin
                errors++;
                $display("FAIL midrst_followup_done cycle %0d got %b required %b", k, done0, (k == 48));
            end
            if (k == 48) begin
                checks++;
                if (y0 !== build_y(3)) begin
                    errors++;
                    $display("FAIL midrst_followup_y got %h required %h", y0, build_y(3));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        start0 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 210; k++) begin
            checks++;
            if (done0 !== ((k % 50) == 48 && k < 200)) begin
                errors++;
                $display("FAIL b2b_done cycle %0d got %b", k, done0);
            end
            checks++;
            if (issue0 !== ((k % 50) <= 5 && k < 200)) begin
                errors++;
                $display("FAIL b2b_issue cycle %0d got %b", k, issue0);
            end
            if ((k % 50) == 48 && k < 200) begin
                checks++;
                if (y0 !== build_y(4 + k / 50)) begin
                    errors++;
                    $display("FAIL b2b_y cycle %0d got %h required %h", k, y0, build_y(4 + k / 50));
                end
            end
            if (k == 199) start0 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_param_sweep;
        start1 = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 20; k++) begin
            start1 = 1'b0;
            checks++;
            if (issue1 !== (k <= 5) || row_sel1 !== ((k <= 5) ? k[2:0] : 3'd0)) begin
                errors++;
                $display("FAIL sweep_issue cycle %0d got %b/%0d", k, issue1, row_sel1);
            end
            checks++;
            if (busy1 !== (k <= 12)) begin
                errors++;
                $display("FAIL sweep_busy cycle %0d got %b required %b", k, busy1, (k <= 12));
            end
            checks++;
            if (done1 !== (k == 13)) begin
                errors++;
                $display("FAIL sweep_done cycle %0d got %b required %b", k, done1, (k == 13));
            end
            if (k == 13) begin
                checks++;
                if (y1 !== build_y(0)) begin
                    errors++;
                    $display("FAIL sweep_y got %h required %h", y1, build_y(0));
                end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_idle;
        rand_mode = 1'b1;
        for (int k = 0; k < 100; k++) begin
            checks++;
            if ({issue0, busy0, done0, issue1, busy1, done1} !== 6'd0) begin
                errors++;
                $display("FAIL idle_ctrl cycle %0d got %b required 000000", k,
                         {issue0, busy0, done0, issue1, busy1, done1});
            end
            checks++;
            if (y0 !== build_y(7)) begin
                errors++;
                $display("FAIL idle_y0 cycle %0d got %h required %h", k, y0, build_y(7));
            end
            checks++;
            if (y1 !== build_y(0)) begin
                errors++;
                $display("FAIL idle_y1 cycle %0d got %h required %h", k, y1, build_y(0));
            end
            @(negedge clk);
        end
        rand_mode = 1'b0;
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        rand_mode = 1'b0;
        resetn    = 1'b0;
        start0    = 1'b0;
        start1    = 1'b0;
        sum0      = 32'd0;
        sum1      = 32'd0;
        pass_cnt0 = 0;
        pass_cnt1 = 0;
        cur_pass0 = 8'd0;
        cur_pass1 = 8'd0;
        for (int i = 0; i < 64; i++) begin
            s0_v[i] = 1'b0; s0_row[i] = 3'd0; s0_pass[i] = 8'd0;
            s1_v[i] = 1'b0; s1_row[i] = 3'd0; s1_pass[i] = 8'd0;
        end
        test_reset();
        test_single();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        test_param_sweep();
        test_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
